// File: rtl/key_sender.sv
// key_sender: sends a fixed six-digit code over a valid/ready key bus and retries until the lock opens
module key_sender #(
  parameter logic [23:0] CODE = 24'h335256,
  parameter int GAP_CYCLES = 2,
  parameter int CHECK_CYCLES = 4,
  parameter int MAX_TRIES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       key_ready,
  input  logic       locked,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] tries
);
  localparam int MX = GAP_CYCLES > CHECK_CYCLES ? GAP_CYCLES : CHECK_CYCLES;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [2:0] {IDLE, SEND, GAP, CHECK, DONE, FAIL} state_t;
  state_t st, st_n;
  logic [2:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] tries_n;
  logic done_n, fail_n;
  logic [3:0] dig;
  assign dig = 4'(CODE >> (4 * (3'd5 - idx_n)));
  always_comb begin
    st_n = st;
    idx_n = idx;
    cnt_n = cnt;
    tries_n = tries;
    done_n = done;
    fail_n = fail;
    case (st)
      IDLE, DONE, FAIL:
        if (start) begin
          st_n = SEND;
          idx_n = 3'd0;
          tries_n = 2'd1;
          done_n = 1'b0;
          fail_n = 1'b0;
        end
      SEND:
        if (key_ready) begin
          if (idx == 3'd5) begin
            st_n = CHECK;
            cnt_n = CW'(CHECK_CYCLES);
          end else begin
            idx_n = idx + 3'd1;
            st_n = GAP_CYCLES == 0 ? SEND : GAP;
            cnt_n = CW'(GAP_CYCLES);
          end
        end
      GAP: begin
        cnt_n = cnt - CW'(1);
        st_n = cnt == CW'(1) ? SEND : GAP;
      end
      CHECK:
        if (!locked) begin
          st_n = DONE;
          done_n = 1'b1;
        end else if (cnt != CW'(1)) begin
          cnt_n = cnt - CW'(1);
        end else if (tries == 2'(MAX_TRIES)) begin
          st_n = FAIL;
          fail_n = 1'b1;
        end else begin
          tries_n = tries + 2'd1;
          idx_n = 3'd0;
          st_n = GAP_CYCLES == 0 ? SEND : GAP;
          cnt_n = CW'(GAP_CYCLES);
        end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      idx <= '0;
      cnt <= '0;
      tries <= '0;
      done <= 1'b0;
      fail <= 1'b0;
      key <= 4'hF;
      key_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      st <= st_n;
      idx <= idx_n;
      cnt <= cnt_n;
      tries <= tries_n;
      done <= done_n;
      fail <= fail_n;
      key <= st_n == SEND ? dig : 4'hF;
      key_valid <= st_n == SEND;
      busy <= st_n inside {SEND, GAP, CHECK};
    end
  end
endmodule
